// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 device-to-host receiver producing qualified 8-bit scan codes
module ps2_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       rx_en,
  output logic [7:0] scan_data,
  output logic       scan_done_tick,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
  localparam logic [1:0] LOAD = 2'd2;

  logic                  c_s1, c_s2, d_s1, d_s2;
  logic [FILTER_LEN-1:0] filt_reg;
  logic                  filt_c_reg, filt_c_next, fall_tick;
  logic [1:0]            state;
  logic [3:0]            n_reg;
  logic [9:0]            b_reg, b_next;
  logic [TW-1:0]         t_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_s1       <= 1'b1;
      c_s2       <= 1'b1;
      d_s1       <= 1'b1;
      d_s2       <= 1'b1;
      filt_reg   <= '1;
      filt_c_reg <= 1'b1;
    end else begin
      c_s1       <= ps2c;
      c_s2       <= c_s1;
      d_s1       <= ps2d;
      d_s2       <= d_s1;
      filt_reg   <= {filt_reg[FILTER_LEN-2:0], c_s2};
      filt_c_reg <= filt_c_next;
    end
  end

  // Hysteresis: the filtered clock only moves once the whole window agrees.
  always_comb begin
    filt_c_next = filt_c_reg;
    if (&filt_reg)
      filt_c_next = 1'b1;
    else if (~|filt_reg)
      filt_c_next = 1'b0;
  end

  assign fall_tick = filt_c_reg & ~filt_c_next;
  assign b_next    = {d_s2, b_reg[9:1]};

  // The verdict is registered on the stop-bit fall so outputs are valid during LOAD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      n_reg          <= 4'd0;
      b_reg          <= 10'd0;
      t_reg          <= '0;
      scan_data      <= 8'h00;
      scan_done_tick <= 1'b0;
      parity_err     <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      scan_done_tick <= 1'b0;
      parity_err     <= 1'b0;
      frame_err      <= 1'b0;
      case (state)
        IDLE: begin
          t_reg <= '0;
          if (fall_tick && rx_en && !d_s2) begin
            state <= DATA;
            n_reg <= 4'd9;
          end
        end
        DATA: begin
          if (fall_tick) begin
            t_reg <= '0;
            b_reg <= b_next;
            if (n_reg == 4'd0) begin
              state <= LOAD;
              if (!b_next[9])
                frame_err <= 1'b1;
              else if (!(^b_next[8:0]))
                parity_err <= 1'b1;
              else begin
                scan_done_tick <= 1'b1;
                scan_data      <= b_next[7:0];
              end
            end else begin
              n_reg <= n_reg - 4'd1;
            end
          end else if (t_reg == T_LAST) begin
            frame_err <= 1'b1;
            state     <= IDLE;
            t_reg     <= '0;
            b_reg     <= 10'd0;
          end else begin
            t_reg <= t_reg + TW'(1);
          end
        end
        LOAD: begin
          state <= IDLE;
          t_reg <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
// tb/tb_ps2_rx.sv - directed and randomized frame checks for ps2_rx
module tb_ps2_rx;

  localparam int FL  = 8;
  localparam int TO  = 2000;
  localparam int H   = 40;
  localparam int LAT = FL + 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ps2c = 1'b1;
  logic       ps2d = 1'b1;
  logic       rx_en = 1'b1;
  logic [7:0] scan_data;
  logic       scan_done_tick, parity_err, frame_err;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_tick = 0, n_perr = 0, n_ferr = 0, n_multi = 0, tick_cyc = 0;
  int stop_cyc = 0;
  logic [7:0] exp_scan = 8'h00;

  ps2_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .ps2c(ps2c), .ps2d(ps2d), .rx_en(rx_en),
    .scan_data(scan_data), .scan_done_tick(scan_done_tick),
    .parity_err(parity_err), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (scan_done_tick) begin
      n_tick   <= n_tick + 1;
      tick_cyc <= cyc;
    end
    if (parity_err) n_perr <= n_perr + 1;
    if (frame_err)  n_ferr <= n_ferr + 1;
    if (32'(scan_done_tick) + 32'(parity_err) + 32'(frame_err) > 1) n_multi <= n_multi + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [10:0] fr, input int first, input int last);
    for (int i = first; i < last; i++) begin
      ps2d = fr[i];
      repeat (H / 2) @(negedge clk);
      ps2c = 1'b0;
      if (i == 10) stop_cyc = cyc;
      repeat (H) @(negedge clk);
      ps2c = 1'b1;
      repeat (H / 2) @(negedge clk);
    end
    ps2d = 1'b1;
  endtask

  task automatic glitch();
    ps2c = 1'b0;
    repeat (3) @(negedge clk);
    ps2c = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  // Reference: odd parity over data+parity, stop must be 1, rx_en gates the start.
  task automatic run_frame(input logic [7:0] d, input logic p, input logic s, input string tag);
    int t0, p0, f0;
    int e_t, e_p, e_f;
    bit en;
    t0 = n_tick; p0 = n_perr; f0 = n_ferr;
    en = rx_en;
    e_t = 0; e_p = 0; e_f = 0;
    if (en) begin
      if (s == 1'b0) e_f = 1;
      else if ((($countones(d) + int'(p)) % 2) == 0) e_p = 1;
      else begin e_t = 1; exp_scan = d; end
    end
    send_bits({s, p, d, 1'b0}, 0, 11);
    repeat (20) @(negedge clk);
    chk({tag, "/tick"}, n_tick - t0, e_t);
    chk({tag, "/perr"}, n_perr - p0, e_p);
    chk({tag, "/ferr"}, n_ferr - f0, e_f);
    chk({tag, "/data"}, scan_data, exp_scan);
    if (e_t == 1) chk({tag, "/lat"}, tick_cyc - stop_cyc, LAT);
  endtask

  function automatic logic odd_p(input logic [7:0] d);
    return ~^d;
  endfunction

  initial begin
    logic [10:0] fr;
    int t0, p0, f0;
    logic [7:0] rd;
    int kind;

    repeat (10) @(negedge clk);
    chk("rst/data", scan_data, 8'h00);
    chk("rst/tick", scan_done_tick, 1'b0);
    chk("rst/perr", parity_err, 1'b0);
    chk("rst/ferr", frame_err, 1'b0);
    reset = 1'b1;
    repeat (20) @(negedge clk);

    run_frame(8'h1C, 1'b0, 1'b1, "t1_1c");
    run_frame(8'hF0, odd_p(8'hF0), 1'b1, "t2_f0");
    run_frame(8'h1C, odd_p(8'h1C), 1'b1, "t2_1c");
    run_frame(8'h1C, 1'b1, 1'b1, "t3_par");
    run_frame(8'h1C, 1'b0, 1'b0, "t3_stop");

    glitch();
    fr = {1'b1, odd_p(8'h32), 8'h32, 1'b0};
    t0 = n_tick;
    send_bits(fr, 0, 4);
    glitch();
    send_bits(fr, 4, 11);
    repeat (20) @(negedge clk);
    exp_scan = 8'h32;
    chk("t4_glitch/tick", n_tick - t0, 1);
    chk("t4_glitch/data", scan_data, exp_scan);

    t0 = n_tick; p0 = n_perr; f0 = n_ferr;
    send_bits({1'b1, odd_p(8'h5A), 8'h5A, 1'b0}, 0, 5);
    repeat (TO + 200) @(negedge clk);
    chk("t5_to/ferr", n_ferr - f0, 1);
    chk("t5_to/tick", n_tick - t0, 0);
    chk("t5_to/perr", n_perr - p0, 0);
    chk("t5_to/data", scan_data, exp_scan);
    run_frame(8'h32, odd_p(8'h32), 1'b1, "t5_next");

    fr = {1'b1, odd_p(8'hA7), 8'hA7, 1'b0};
    t0 = n_tick;
    send_bits(fr, 0, 4);
    rx_en = 1'b0;
    send_bits(fr, 4, 11);
    repeat (20) @(negedge clk);
    exp_scan = 8'hA7;
    chk("en_drop/tick", n_tick - t0, 1);
    chk("en_drop/data", scan_data, exp_scan);

    rx_en = 1'b1;
    send_bits({1'b1, odd_p(8'h6B), 8'h6B, 1'b0}, 0, 4);
    t0 = n_tick;
    reset = 1'b0;
    #1;
    chk("t6_rst/data", scan_data, 8'h00);
    chk("t6_rst/tick", scan_done_tick, 1'b0);
    chk("t6_rst/ferr", frame_err, 1'b0);
    exp_scan = 8'h00;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("t6_rst/none", n_tick - t0, 0);
    rx_en = 1'b0;
    run_frame(8'h29, odd_p(8'h29), 1'b1, "t6_dis");
    rx_en = 1'b1;
    run_frame(8'h29, odd_p(8'h29), 1'b1, "t6_en");

    for (int i = 0; i < 8; i++) begin
      rd = 8'($urandom);
      kind = int'($urandom_range(0, 3));
      case (kind)
        2:       run_frame(rd, ~odd_p(rd), 1'b1, "rnd_par");
        3:       run_frame(rd, odd_p(rd), 1'b0, "rnd_stop");
        default: run_frame(rd, odd_p(rd), 1'b1, "rnd_good");
      endcase
    end

    chk("multi_tick", n_multi, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
